// File: rtl/pcie_rx_tlp_router_if.sv
// Receive-side TLP router bus: inbound beat stream plus per-class
// header/payload outputs, credit-return pulses and error status.
interface pcie_rx_tlp_router_if #(
    parameter int unsigned DATA_WIDTH = 256
);
    logic                       tlp_in_valid;
    logic                       tlp_in_ready;
    logic [DATA_WIDTH-1:0]      tlp_in_data;
    logic                       tlp_in_last;

    logic [2:0]                 hdr_valid;
    logic [2:0]                 hdr_ready;
    logic [2:0][127:0]          hdr_data;

    logic [2:0]                 pay_valid;
    logic [2:0]                 pay_ready;
    logic [2:0][DATA_WIDTH-1:0] pay_data;
    logic [2:0]                 pay_last;

    logic [2:0]                 cr_hdr_ret;
    logic [2:0]                 cr_dat_ret;
    logic                       err_malformed;
    logic [15:0]                err_drop_cnt;

    // Upstream link layer / downstream consumers side
    modport master (
        output tlp_in_valid, tlp_in_data, tlp_in_last, hdr_ready, pay_ready,
        input  tlp_in_ready, hdr_valid, hdr_data, pay_valid, pay_data, pay_last,
               cr_hdr_ret, cr_dat_ret, err_malformed, err_drop_cnt
    );

    // Router side
    modport slave (
        input  tlp_in_valid, tlp_in_data, tlp_in_last, hdr_ready, pay_ready,
        output tlp_in_ready, hdr_valid, hdr_data, pay_valid, pay_data, pay_last,
               cr_hdr_ret, cr_dat_ret, err_malformed, err_drop_cnt
    );
endinterface

// File: rtl/pcie_rx_tlp_router.sv
// PCIe RX TLP router: classifies each TLP into P / NP / CPL, stores header
// and payload in per-class FWFT FIFOs, drops unsupported TLPs, flags
// length/last mismatches and returns credits as consumers drain.
module pcie_rx_tlp_router #(
    parameter int unsigned DATA_WIDTH    = 256,
    parameter int unsigned HDR_DEPTH_LG2 = 4,
    parameter int unsigned PAY_DEPTH_LG2 = 5
) (
    input logic                 clk,
    input logic                 rst,
    pcie_rx_tlp_router_if.slave tlp
);
    localparam int unsigned DW_PER_BEAT = DATA_WIDTH / 32;
    localparam int unsigned HDR_DEPTH   = 1 << HDR_DEPTH_LG2;
    localparam int unsigned PAY_DEPTH   = 1 << PAY_DEPTH_LG2;
    localparam logic [HDR_DEPTH_LG2:0] HDR_ONE = 1;
    localparam logic [PAY_DEPTH_LG2:0] PAY_ONE = 1;

    typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;
    typedef enum logic [1:0] {CLS_P = 2'd0, CLS_NP = 2'd1, CLS_CPL = 2'd2} cls_t;

    state_t      state_q, state_d;
    cls_t        cls_q, cls_d;
    logic [10:0] cnt_q, cnt_d;

    logic [2:0]  dec_fmt;
    logic [4:0]  dec_type;
    logic [9:0]  dec_len;
    logic [10:0] dec_dw;
    logic [10:0] dec_beats;
    logic        dec_sup;
    logic        dec_pay;
    cls_t        dec_cls;

    logic        rdy;
    logic        acc;
    logic        mal_d;
    logic        drop_inc;
    logic [2:0]  hdr_push, pay_push, hdr_pop, pay_pop;
    logic [2:0]  hdr_full, pay_full;

    logic [2:0]                 hdr_valid_w, pay_valid_w, pay_last_w;
    logic [2:0][127:0]          hdr_data_w;
    logic [2:0][DATA_WIDTH-1:0] pay_data_w;

    logic [2:0]  cr_hdr_q, cr_dat_q;
    logic        err_mal_q;
    logic [15:0] drop_cnt_q;

    // Header decode of the current beat (only meaningful in IDLE)
    always_comb begin
        dec_fmt   = tlp.tlp_in_data[31:29];
        dec_type  = tlp.tlp_in_data[28:24];
        dec_len   = tlp.tlp_in_data[9:0];
        dec_dw    = (dec_len == '0) ? 11'd1024 : {1'b0, dec_len};
        dec_beats = 11'((32'(dec_dw) + DW_PER_BEAT - 1) / DW_PER_BEAT);
        dec_sup   = 1'b0;
        dec_pay   = 1'b0;
        dec_cls   = CLS_P;
        if (dec_type == 5'b00000 && dec_fmt[2:1] == 2'b00) begin
            dec_sup = 1'b1;
            dec_cls = CLS_NP;
        end else if (dec_type == 5'b00000 && dec_fmt[2:1] == 2'b01) begin
            dec_sup = 1'b1;
            dec_pay = 1'b1;
            dec_cls = CLS_P;
        end else if (dec_type == 5'b01010 && dec_fmt == 3'b000) begin
            dec_sup = 1'b1;
            dec_cls = CLS_CPL;
        end else if (dec_type == 5'b01010 && dec_fmt == 3'b010) begin
            dec_sup = 1'b1;
            dec_pay = 1'b1;
            dec_cls = CLS_CPL;
        end
    end

    // Inbound ready: headers wait for FIFO room, payload beats stall individually
    always_comb begin
        case (state_q)
            IDLE:    rdy = dec_sup ? !hdr_full[dec_cls] : 1'b1;
            PAYLOAD: rdy = !pay_full[cls_q];
            default: rdy = 1'b1;
        endcase
        rdy = rdy && !rst;
    end

    assign acc              = tlp.tlp_in_valid && rdy;
    assign tlp.tlp_in_ready = rdy;

    // FSM state and per-TLP context registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cls_q   <= CLS_P;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, FIFO pushes and error detection for each accepted beat
    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        cnt_d    = cnt_q;
        hdr_push = '0;
        pay_push = '0;
        mal_d    = 1'b0;
        drop_inc = 1'b0;
        if (acc) begin
            case (state_q)
                IDLE: begin
                    if (dec_sup) begin
                        hdr_push[dec_cls] = 1'b1;
                        if (dec_pay && !tlp.tlp_in_last) begin
                            state_d = PAYLOAD;
                            cls_d   = dec_cls;
                            cnt_d   = dec_beats;
                        end else if (dec_pay || !tlp.tlp_in_last) begin
                            mal_d = 1'b1;
                            if (!tlp.tlp_in_last) state_d = DROP;
                        end
                    end else begin
                        drop_inc = 1'b1;
                        if (!tlp.tlp_in_last) state_d = DROP;
                    end
                end
                PAYLOAD: begin
                    pay_push[cls_q] = 1'b1;
                    cnt_d = (cnt_q != '0) ? cnt_q - 11'd1 : '0;
                    if (tlp.tlp_in_last) begin
                        state_d = IDLE;
                        mal_d   = (cnt_q != 11'd1);
                    end else begin
                        // counter hits zero with more beats still coming
                        mal_d = (cnt_q == 11'd1);
                    end
                end
                default: begin
                    if (tlp.tlp_in_last) state_d = IDLE;
                end
            endcase
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_cls
        logic [127:0]           hdr_mem [HDR_DEPTH];
        logic [HDR_DEPTH_LG2:0] hdr_wp, hdr_rp;
        logic [DATA_WIDTH:0]    pay_mem [PAY_DEPTH];
        logic [PAY_DEPTH_LG2:0] pay_wp, pay_rp;
        logic [DATA_WIDTH:0]    pay_rd;

        // FIFO storage writes (no reset needed, pointers define validity)
        always_ff @(posedge clk) begin
            if (hdr_push[c]) hdr_mem[hdr_wp[HDR_DEPTH_LG2-1:0]] <= tlp.tlp_in_data[127:0];
            if (pay_push[c]) pay_mem[pay_wp[PAY_DEPTH_LG2-1:0]] <= {tlp.tlp_in_last, tlp.tlp_in_data};
        end

        // FIFO pointers; the extra MSB separates full from empty
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hdr_wp <= '0;
                hdr_rp <= '0;
                pay_wp <= '0;
                pay_rp <= '0;
            end else begin
                if (hdr_push[c]) hdr_wp <= hdr_wp + HDR_ONE;
                if (hdr_pop[c])  hdr_rp <= hdr_rp + HDR_ONE;
                if (pay_push[c]) pay_wp <= pay_wp + PAY_ONE;
                if (pay_pop[c])  pay_rp <= pay_rp + PAY_ONE;
            end
        end

        assign hdr_valid_w[c] = (hdr_wp != hdr_rp);
        assign hdr_full[c]    = (hdr_wp[HDR_DEPTH_LG2] != hdr_rp[HDR_DEPTH_LG2]) &&
                                (hdr_wp[HDR_DEPTH_LG2-1:0] == hdr_rp[HDR_DEPTH_LG2-1:0]);
        assign hdr_data_w[c]  = hdr_mem[hdr_rp[HDR_DEPTH_LG2-1:0]];
        assign hdr_pop[c]     = hdr_valid_w[c] && tlp.hdr_ready[c];

        assign pay_valid_w[c] = (pay_wp != pay_rp);
        assign pay_full[c]    = (pay_wp[PAY_DEPTH_LG2] != pay_rp[PAY_DEPTH_LG2]) &&
                                (pay_wp[PAY_DEPTH_LG2-1:0] == pay_rp[PAY_DEPTH_LG2-1:0]);
        assign pay_rd         = pay_mem[pay_rp[PAY_DEPTH_LG2-1:0]];
        assign pay_data_w[c]  = pay_rd[DATA_WIDTH-1:0];
        assign pay_last_w[c]  = pay_rd[DATA_WIDTH];
        assign pay_pop[c]     = pay_valid_w[c] && tlp.pay_ready[c];
    end

    // Registered credit pulses, malformed pulse and saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cr_hdr_q   <= '0;
            cr_dat_q   <= '0;
            err_mal_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            cr_hdr_q  <= hdr_pop;
            cr_dat_q  <= pay_pop;
            err_mal_q <= mal_d;
            if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign tlp.hdr_valid     = hdr_valid_w;
    assign tlp.hdr_data      = hdr_data_w;
    assign tlp.pay_valid     = pay_valid_w;
    assign tlp.pay_data      = pay_data_w;
    assign tlp.pay_last      = pay_last_w;
    assign tlp.cr_hdr_ret    = cr_hdr_q;
    assign tlp.cr_dat_ret    = cr_dat_q;
    assign tlp.err_malformed = err_mal_q;
    assign tlp.err_drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_pcie_rx_tlp_router.sv
// Directed bench for pcie_rx_tlp_router (DATA_WIDTH = 256, default depths).
module tb_pcie_rx_tlp_router;
    logic clk;
    logic rst;
    int unsigned n_checks;
    int unsigned n_fail;

    pcie_rx_tlp_router_if #(.DATA_WIDTH(256)) bus ();

    pcie_rx_tlp_router #(
        .DATA_WIDTH   (256),
        .HDR_DEPTH_LG2(4),
        .PAY_DEPTH_LG2(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tlp(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_hdr(input logic [2:0] fmt, input logic [4:0] typ,
                                            input logic [9:0] len, input logic [31:0] tag);
        logic [255:0] h;
        h          = '0;
        h[31:29]   = fmt;
        h[28:24]   = typ;
        h[9:0]     = len;
        h[127:96]  = tag;
        return h;
    endfunction

    // Present one beat from posedge+1, hold until accepted, return at posedge+1
    task automatic send(input logic [255:0] d, input logic l, output int unsigned waited);
        bus.tlp_in_valid = 1'b1;
        bus.tlp_in_data  = d;
        bus.tlp_in_last  = l;
        waited = 0;
        @(negedge clk);
        while (!bus.tlp_in_ready && waited < 64) begin
            waited++;
            @(negedge clk);
        end
        check("accept_timeout", 64'(waited < 64), 64'd1);
        @(posedge clk);
        #1;
        bus.tlp_in_valid = 1'b0;
    endtask

    task automatic drain_all();
        bus.hdr_ready = 3'b111;
        bus.pay_ready = 3'b111;
        repeat (4) @(posedge clk);
        #1;
        bus.hdr_ready = '0;
        bus.pay_ready = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] h, pa, pb, pc;
        int unsigned w, wsum, cnt;

        n_checks = 0;
        n_fail   = 0;
        pa = {4{64'h1111_2222_3333_0001}};
        pb = {4{64'h4444_5555_6666_0002}};
        pc = {4{64'h7777_8888_9999_0003}};

        rst = 1'b1;
        bus.tlp_in_valid = 1'b0;
        bus.tlp_in_data  = '0;
        bus.tlp_in_last  = 1'b0;
        bus.hdr_ready    = '0;
        bus.pay_ready    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready",     bus.tlp_in_ready,  0);
        check("rst_hdr_valid", bus.hdr_valid,     0);
        check("rst_pay_valid", bus.pay_valid,     0);
        check("rst_cr",        {bus.cr_hdr_ret, bus.cr_dat_ret}, 0);
        check("rst_err",       bus.err_malformed, 0);
        check("rst_drop",      bus.err_drop_cnt,  0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // MWr len=16 -> header + 2 payload beats
        h = mk_hdr(3'b010, 5'b00000, 10'd16, 32'hA0);
        send(h, 1'b0, w);
        check("mwr_hdr_lat", bus.hdr_valid, 3'b001);
        send(pa, 1'b0, w);
        send(pb, 1'b1, w);
        check("mwr_hdr_valid", bus.hdr_valid, 3'b001);
        check("mwr_hdr_dw0",   bus.hdr_data[0][63:0], h[63:0]);
        check("mwr_pay_valid", bus.pay_valid, 3'b001);
        check("mwr_pay0_data", bus.pay_data[0][63:0], pa[63:0]);
        check("mwr_pay0_last", bus.pay_last[0], 0);
        check("mwr_err",       bus.err_malformed, 0);
        bus.hdr_ready = 3'b001;
        bus.pay_ready = 3'b001;
        @(posedge clk);
        #1;
        bus.hdr_ready = '0;
        check("mwr_cr_hdr1",   bus.cr_hdr_ret, 3'b001);
        check("mwr_cr_dat1",   bus.cr_dat_ret, 3'b001);
        check("mwr_pay1_data", bus.pay_data[0][63:0], pb[63:0]);
        check("mwr_pay1_last", bus.pay_last[0], 1);
        @(posedge clk);
        #1;
        bus.pay_ready = '0;
        check("mwr_cr_hdr2",   bus.cr_hdr_ret, 0);
        check("mwr_cr_dat2",   bus.cr_dat_ret, 3'b001);
        check("mwr_empty",     {bus.hdr_valid, bus.pay_valid}, 0);
        @(posedge clk);
        #1;
        check("mwr_cr_dat3",   bus.cr_dat_ret, 0);

        // MRd single beat -> NP header only
        h = mk_hdr(3'b001, 5'b00000, 10'd1, 32'hB0);
        send(h, 1'b1, w);
        check("mrd_hdr_valid", bus.hdr_valid, 3'b010);
        check("mrd_tag",       bus.hdr_data[1][127:96], 32'hB0);
        check("mrd_pay_valid", bus.pay_valid, 0);
        check("mrd_err",       bus.err_malformed, 0);
        bus.hdr_ready = 3'b010;
        @(posedge clk);
        #1;
        bus.hdr_ready = '0;
        check("mrd_cr_hdr",    bus.cr_hdr_ret, 3'b010);

        // CfgRd0, 2 beats -> dropped
        send(mk_hdr(3'b000, 5'b00100, 10'd1, 32'hC0), 1'b0, w);
        check("cfg_rdy0", w, 0);
        send(pa, 1'b1, w);
        check("cfg_rdy1", w, 0);
        check("cfg_drop_cnt", bus.err_drop_cnt, 1);
        check("cfg_nothing",  {bus.hdr_valid, bus.pay_valid}, 0);
        check("cfg_err",      bus.err_malformed, 0);

        // Header FIFO backpressure on NP
        wsum = 0;
        for (int i = 0; i < 16; i++) begin
            send(mk_hdr(3'b001, 5'b00000, 10'd1, 32'(i)), 1'b1, w);
            wsum += w;
        end
        check("bp_fill_waits", wsum, 0);
        bus.tlp_in_valid = 1'b1;
        bus.tlp_in_data  = mk_hdr(3'b001, 5'b00000, 10'd1, 32'd16);
        bus.tlp_in_last  = 1'b1;
        @(negedge clk);
        check("bp_full_rdy", bus.tlp_in_ready, 0);
        @(posedge clk);
        #1;
        bus.hdr_ready = 3'b010;
        @(negedge clk);
        check("bp_pop_rdy", bus.tlp_in_ready, 0);
        @(posedge clk);
        #1;
        bus.hdr_ready = '0;
        @(negedge clk);
        check("bp_after_pop_rdy", bus.tlp_in_ready, 1);
        @(posedge clk);
        #1;
        bus.tlp_in_valid = 1'b0;
        check("bp_refull_rdy", bus.tlp_in_ready, 0);
        check("bp_head_tag",   bus.hdr_data[1][127:96], 32'd1);
        bus.hdr_ready = 3'b010;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.hdr_valid[1]) cnt++;
        end
        bus.hdr_ready = '0;
        check("bp_entries", cnt, 16);
        @(posedge clk);
        #1;

        // Malformed MWr: last on first of two expected payload beats
        send(mk_hdr(3'b010, 5'b00000, 10'd16, 32'hD0), 1'b0, w);
        send(pc, 1'b1, w);
        check("malf_err",       bus.err_malformed, 1);
        check("malf_pay_valid", bus.pay_valid, 3'b001);
        check("malf_pay_last",  bus.pay_last, 3'b001);
        check("malf_pay_data",  bus.pay_data[0][63:0], pc[63:0]);
        @(posedge clk);
        #1;
        check("malf_err_once",  bus.err_malformed, 0);
        send(mk_hdr(3'b001, 5'b00000, 10'd1, 32'hD1), 1'b1, w);
        check("malf_idle", bus.hdr_valid, 3'b011);
        drain_all();

        // CplD len=8 -> one payload beat on CPL class
        send(mk_hdr(3'b010, 5'b01010, 10'd8, 32'hE0), 1'b0, w);
        send(pb, 1'b1, w);
        check("cpld_hdr_valid", bus.hdr_valid, 3'b100);
        check("cpld_pay_valid", bus.pay_valid, 3'b100);
        check("cpld_pay_last",  bus.pay_last[2], 1);
        check("cpld_err",       bus.err_malformed, 0);
        drain_all();

        // Reset in the middle of a 4-beat MWr
        send(mk_hdr(3'b010, 5'b00000, 10'd32, 32'hF0), 1'b0, w);
        send(pa, 1'b0, w);
        check("mid_pay_valid", bus.pay_valid, 3'b001);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valids", {bus.hdr_valid, bus.pay_valid}, 0);
        check("mid_rst_ready",  bus.tlp_in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(mk_hdr(3'b001, 5'b00000, 10'd1, 32'hF1), 1'b1, w);
        check("post_rst_hdr",  bus.hdr_valid, 3'b010);
        check("post_rst_tag",  bus.hdr_data[1][127:96], 32'hF1);
        check("post_rst_pay",  bus.pay_valid, 0);
        check("post_rst_err",  bus.err_malformed, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
